// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, receiver and transmitter state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  // Receiver states
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t IDLE  = 2'd0;
  localparam rx_state_t SHIFT = 2'd1;
  localparam rx_state_t ABORT = 2'd2;

  // Master (transmit side) states
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_SHIFT = 2'd1;
  localparam tx_state_t TX_DONE  = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with extra-bit pointers for full/empty.
// Latency: a pushed entry is visible on pop_dat_o the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports: clk/rst (sync, active-high), push_i/push_dat_i write side,
//        pop_i/pop_dat_o read side (data is zero while empty), full_o/empty_o status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  // Same slot index but wrap bits differ: writer is a full lap ahead.
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the head slot this edge, so a push at full still fits.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  // Stale storage is masked so the output reads zero after reset or when drained.
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receiver: synchronizes sclk/mosi/cs_n, rebuilds MSB-first bytes, buffers them in a FIFO.
// Latency: byte is pushed on the edge its 8th sclk rise is seen (SYNC_STAGES+1 edges after pin capture).
// Backpressure: out_valid/out_ready stream; a byte completing into a full FIFO with no pop is dropped (overrun).
// Ports: clk/rst (sync, active-high); sclk_in/mosi_in/cs_n SPI pins;
//        out_data/out_valid/out_ready byte stream; clr_status clears sticky
//        overrun/frame_err; checksum is the XOR of every byte accepted by the FIFO.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  cs_n,
  output logic [SPI_BYTE_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_status,
  output logic                  overrun,
  output logic                  frame_err,
  output logic [31:0]           checksum
);

  // Synchronizer bundle order is {cs, mosi, sclk}; cs idles high.
  localparam logic [2:0] SYNC_RST = 3'b100;

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    logic [2:0] stage_q;
    logic [2:0] stage_in;
    if (g == 0) begin : g_head
      assign stage_in = {cs_n, mosi_in, sclk_in};
    end else begin : g_tail
      assign stage_in = g_sync[g-1].stage_q;
    end
    always_ff @(posedge clk) begin
      if (rst) stage_q <= SYNC_RST;
      else     stage_q <= stage_in;
    end
  end

  logic cs_s, mosi_s, sclk_s;
  assign {cs_s, mosi_s, sclk_s} = g_sync[SYNC_STAGES-1].stage_q;

  logic sclk_d_q;
  logic rise;
  assign rise = sclk_s & ~sclk_d_q;

  rx_state_t             state_q, state_d;
  logic [SPI_BYTE_W-1:0] shreg_q, shreg_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  byte_done;
  logic                  abort_set;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    byte_done = 1'b0;
    abort_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 3'd0;
        if (!cs_s) state_d = SHIFT;
      end
      SHIFT: begin
        // cs deassertion takes priority over a coincident sclk rise.
        if (cs_s) begin
          state_d = (cnt_q != 3'd0) ? ABORT : IDLE;
        end else if (rise) begin
          shreg_d   = {shreg_q[SPI_BYTE_W-2:0], mosi_s};
          cnt_d     = cnt_q + 3'd1;
          byte_done = (cnt_q == 3'd7);
        end
      end
      ABORT: begin
        abort_set = 1'b1;
        shreg_d   = '0;
        cnt_d     = 3'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  logic fifo_full, fifo_empty, pop, push_ok, ovr_set;

  assign pop       = out_valid & out_ready;
  assign push_ok   = byte_done & (~fifo_full | pop);
  assign ovr_set   = byte_done & fifo_full & ~pop;
  assign out_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (byte_done),
    .push_dat_i (shreg_d),
    .pop_i      (pop),
    .pop_dat_o  (out_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  logic [31:0] checksum_q, checksum_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;

  always_comb begin
    checksum_d  = checksum_q;
    if (push_ok) checksum_d = checksum_q ^ {24'd0, shreg_d};
    // A new event in the same cycle as clr_status keeps the flag set.
    overrun_d   = ovr_set   | (overrun_q   & ~clr_status);
    frame_err_d = abort_set | (frame_err_q & ~clr_status);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d_q    <= 1'b0;
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= 3'd0;
      checksum_q  <= 32'd0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_d_q    <= sclk_s;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      checksum_q  <= checksum_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign checksum  = checksum_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: stimulus pushes expected bytes, a monitor pops on handshakes.
// Latency: n/a.
// Backpressure: out_ready is driven directly or randomized per cycle.
module tb_spi_slave_rx;

  logic        clk;
  logic        rst;
  logic        sclk_in;
  logic        mosi_in;
  logic        cs_n;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clr_status;
  logic        overrun;
  logic        frame_err;
  logic [31:0] checksum;

  logic        rdy_dir;
  logic        rnd_rdy;
  logic        rand_mode;

  int          total;
  int          bad;
  int          vld_cycles;
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] chk_m;

  spi_slave_rx #(
    .SYNC_STAGES (2),
    .DEPTH       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk_in    (sclk_in),
    .mosi_in    (mosi_in),
    .cs_n       (cs_n),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .clr_status (clr_status),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .checksum   (checksum)
  );

  assign out_ready = rand_mode ? rnd_rdy : rdy_dir;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rnd_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1 rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, i.e. the state the next rising edge acts on.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) vld_cycles++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got 0x%0h want no byte", out_data);
          end else begin
            e = exp_q.pop_front();
            check("pop_data", {24'd0, out_data}, {24'd0, e});
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int ph);
    mosi_in = b;
    cyc(ph);
    sclk_in = 1'b1;
    cyc(ph);
    sclk_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int ph);
    for (int i = 7; i >= 0; i--) send_bit(b[i], ph);
  endtask

  // Sends tx_q as one frame; only the first accept_n bytes are expected to land.
  // tail_bits > 0 appends a partial byte before cs_n rises.
  task automatic send_frame(input int accept_n, input int ph, input int tail_bits,
                            input logic [7:0] tail_byte);
    cs_n = 1'b0;
    cyc(4);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i < accept_n) begin
        exp_q.push_back(tx_q[i]);
        chk_m = chk_m ^ {24'd0, tx_q[i]};
      end
      send_byte(tx_q[i], ph);
    end
    for (int i = 0; i < tail_bits; i++) send_bit(tail_byte[7-i], ph);
    cyc(ph);
    cs_n = 1'b1;
    cyc(8);
    tx_q.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      cyc(1);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic clear_status();
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
    cyc(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},    {31'd0, out_valid}, 32'd0);
    check({tag, "_data"},     {24'd0, out_data},  32'd0);
    check({tag, "_overrun"},  {31'd0, overrun},   32'd0);
    check({tag, "_frameerr"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_checksum"}, checksum,           32'd0);
  endtask

  initial begin
    total = 0; bad = 0; vld_cycles = 0; chk_m = 32'd0;
    rst = 1'b1; cs_n = 1'b1; sclk_in = 1'b0; mosi_in = 1'b0;
    rdy_dir = 1'b0; rand_mode = 1'b0; clr_status = 1'b0;
    cyc(3);
    check_reset_vals("rst");
    rst = 1'b0;
    cyc(3);

    // Single byte with out_ready held high: exactly one valid cycle.
    rdy_dir = 1'b1;
    vld_cycles = 0;
    tx_q.push_back(8'hA5);
    send_frame(99, 8, 0, 8'h00);
    drain();
    check("single_vld_cycles", vld_cycles, 1);
    check("single_checksum", checksum, chk_m);

    // Three back-to-back bytes.
    tx_q.push_back(8'h3C); tx_q.push_back(8'hFF); tx_q.push_back(8'h00);
    send_frame(99, 8, 0, 8'h00);
    drain();
    check("b2b_checksum", checksum, chk_m);
    check("b2b_no_overrun", {31'd0, overrun}, 32'd0);

    // Overrun: five bytes into a 4-deep FIFO with no consumer.
    rdy_dir = 1'b0;
    for (int i = 1; i <= 5; i++) tx_q.push_back(8'(i));
    send_frame(4, 4, 0, 8'h00);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_checksum", checksum, chk_m);
    check("ovr_valid", {31'd0, out_valid}, 32'd1);
    clear_status();
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    rdy_dir = 1'b1;
    drain();

    // Frame abort after 5 bits of 0xF0, then a clean byte.
    send_frame(0, 5, 5, 8'hF0);
    check("abort_flag", {31'd0, frame_err}, 32'd1);
    check("abort_checksum", checksum, chk_m);
    check("abort_no_write", {31'd0, out_valid}, 32'd0);
    tx_q.push_back(8'h81);
    send_frame(99, 5, 0, 8'h00);
    drain();
    check("after_abort_checksum", checksum, chk_m);
    clear_status();
    check("abort_cleared", {31'd0, frame_err}, 32'd0);

    // Push and pop in the same edge while full.
    rdy_dir = 1'b0;
    cs_n = 1'b0;
    cyc(4);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      chk_m = chk_m ^ i;
      send_byte(8'(i), 8);
    end
    exp_q.push_back(8'h55);
    chk_m = chk_m ^ 32'h55;
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h55 >> i), 8);
    mosi_in = 1'b1;
    cyc(8);
    sclk_in = 1'b1;
    // Rise is acted on three edges after this pin change; ready covers only that edge.
    cyc(2);
    rdy_dir = 1'b1;
    cyc(1);
    rdy_dir = 1'b0;
    cyc(7);
    sclk_in = 1'b0;
    cyc(8);
    cs_n = 1'b1;
    cyc(8);
    check("simul_no_overrun", {31'd0, overrun}, 32'd0);
    check("simul_checksum", checksum, chk_m);
    rdy_dir = 1'b1;
    drain();

    // Reset in the middle of a frame.
    cs_n = 1'b0;
    cyc(4);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 4);
    rst = 1'b1;
    cyc(2);
    check_reset_vals("midrst");
    chk_m = 32'd0;
    exp_q.delete();
    cs_n = 1'b1;
    sclk_in = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    tx_q.push_back(8'h7E);
    send_frame(99, 4, 0, 8'h00);
    drain();
    check("post_rst_checksum", checksum, chk_m);

    // Randomized frames, randomized consumer, occasional partial tails.
    rand_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      int nb, ph, tb;
      nb = $urandom_range(1, 3);
      ph = $urandom_range(3, 6);
      tb = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
      send_frame(99, ph, tb, 8'($urandom));
      check("rand_checksum", checksum, chk_m);
      check("rand_frame_err", {31'd0, frame_err}, (tb != 0) ? 32'd1 : 32'd0);
      if (tb != 0) clear_status();
    end
    drain();
    rand_mode = 1'b0;
    check("final_overrun", {31'd0, overrun}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side companion to the SPI master in the same design: samples the master's `sclk`/`mosi` lines plus a `cs_n` frame strobe, reassembles MSB-first bytes, and buffers them in a small FIFO. Bytes leave on a valid/ready stream. The block also keeps a running XOR checksum and frame/overrun status, so the self-checking top level can compare received data against transmitted data.

## Interface
- `SYNC_STAGES`, default 2: flops in each input synchronizer (legal range 2..3).
- `DEPTH`, default 4: FIFO depth in bytes (power of two, ≥2).
- `clk  in  1`: system clock; all logic is on its rising edge.
- `rst  in  1`: reset; synchronous, active-high.
- `sclk_in  in  1`: SPI clock from the master; slower than `clk`.
- `mosi_in  in  1`: serial data, MSB first.
- `cs_n  in  1`: frame select, active-low.
- `out_data  out  8`: head-of-FIFO byte.
- `out_valid  out  1`: FIFO not empty.
- `out_ready  in  1`: consumer accepts `out_data` when `out_valid & out_ready`.
- `clr_status  in  1`: clears `overrun` and `frame_err`.
- `overrun  out  1`: sticky; a completed byte was dropped because the FIFO was full.
- `frame_err  out  1`: sticky; `cs_n` rose with a partial byte pending.
- `checksum  out  32`: running XOR of `{24'd0, byte}` over every byte written to the FIFO.

## Operation
- **Synchronizer.** `sclk_in`, `mosi_in` and `cs_n` each pass through `SYNC_STAGES` flops, giving `sclk_s`, `mosi_s` and `cs_s`.
- **Edge detect.** `sclk_d` is `sclk_s` delayed one cycle. `rise = sclk_s & ~sclk_d`.
- **States (`rx_state_t`).**
  - `IDLE`: `cs_s` is high. `bit_cnt` is held at 0. Goes to `SHIFT` when `cs_s` goes low.
  - `SHIFT`: on each `rise`, `shreg <= {shreg[6:0], mosi_s}` and `bit_cnt` increments (3-bit, wraps 7→0).
    - On the `rise` where `bit_cnt == 7`, the byte `{shreg[6:0], mosi_s}` completes: it is pushed to the FIFO and `checksum` updates in the same edge.
    - If `cs_s` goes high while in `SHIFT` with `bit_cnt != 0`: go to `ABORT`. If `bit_cnt == 0`: go to `IDLE`.
  - `ABORT`: for one cycle, sets `frame_err`, discards `shreg`, clears `bit_cnt`, then goes to `IDLE`.
- **Back-to-back bytes.** Consecutive bytes within one frame need no gap. `bit_cnt` wrapping to 0 starts the next byte.
- **Push when full.**
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped, `overrun` is set and `checksum` is not updated.
  - If a pop happens in the same cycle, the push is accepted.
- **`rise` coincident with `cs_s` rising.** `cs_s` wins: the edge is ignored.
- **`clr_status` coincident with a new overrun or frame error.** The set wins.
- **Reset.** Reset mid-frame drops all state, including FIFO contents. Reset values:
  - `out_valid = 0`, `out_data = 8'd0`, `overrun = 0`, `frame_err = 0`, `checksum = 32'd0`.
  - State is `IDLE`; `shreg` and `bit_cnt` are 0; all synchronizer flops are 1 for `cs_n` and 0 for the other inputs.

## Timing
- Input-to-`rise` latency is `SYNC_STAGES + 1` `clk` edges after a pin transition is first captured.
- The FIFO write happens on the edge where `rise` with `bit_cnt == 7` is seen. `out_valid` goes high after that same edge (registered FIFO state, show-ahead data).
- Pop takes effect on the edge where `out_valid & out_ready`. The next byte, if any, is on `out_data` right after that edge.
- `sclk_in` high and low phases must each be ≥ `SYNC_STAGES + 1` `clk` cycles. Faster clocks are unsupported and untested.
- Sticky flags assert on the edge that detects the event.

## Structure
- `spi_pkg`: holds `rx_state_t` (`IDLE`, `SHIFT`, `ABORT`; logic [1:0]) and the `SPI_BYTE_W = 8` constant. The master's state enum moves into this package as well.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`: read/write pointers one bit wider than needed for full/empty detection, show-ahead output, simultaneous push/pop allowed when full.
- The synchronizer is an inline generate loop; it gets no separate module.

## Test plan
- **Single byte.** Drive `cs_n` low, send 0xA5 MSB-first at 8 `clk` cycles per `sclk` phase, hold `out_ready = 1`.
  - Expect `out_data = 0xA5` with `out_valid` pulsed for one cycle, and `checksum = 0x000000A5`.
- **Three back-to-back bytes in one frame.** Send 0x3C, 0xFF, 0x00.
  - Expect pops in that order and `checksum = 0x000000C3`.
- **Overrun.** With `DEPTH = 4` and `out_ready = 0`, send 5 bytes 0x01..0x05.
  - Expect `overrun = 1`, FIFO holding 0x01..0x04, `checksum = 0x04`.
  - Then `clr_status` → `overrun = 0`.
- **Frame abort.** Raise `cs_n` after 5 bits of 0xF0.
  - Expect `frame_err = 1`, no FIFO write, `checksum` unchanged.
  - A following full byte 0x81 is received correctly.
- **Simultaneous push/pop at full.** Fill 4 bytes, then assert `out_ready` in exactly the cycle the 5th byte (0x55) completes.
  - Expect no overrun, and 0x55 is the 4th byte popped after the first.
- **Reset mid-frame.** Assert `rst` after 3 bits.
  - Expect all outputs at reset values.
  - The next frame sending 0x7E yields exactly 0x7E.
